mem_wait_ctrl: RTL and testbench

Parametrised word-addressed data memory for the multicycle CPU. It replaces the fixed 32x128 tri-state RAM with a request/acknowledge slave interface. The block adds programmable wait states, byte-lane write enables, two memory-mapped I/O registers (LED output, switch input) and an out-of-range error flag. It sits between the CPU memory port and the board I/O, on the same clock as the CPU.

---
 rtl/mem_wait_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_wait_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: word-addressed data memory with a request/acknowledge
// slave port, programmable wait states, byte-lane write enables, an LED
// output register, a switch input port and an out-of-range error flag.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   REQ    in   access request
//   WE     in   1 = write, 0 = read (sampled with REQ)
//   ADDR   in   word address
//   WDATA  in   write data
//   BE     in   byte-lane write enables (ignored on reads)
//   RDATA  out  read data, valid while ACK=1, held until the next access
//   ACK    out  one-cycle completion pulse
//   ERR    out  address error, valid while ACK=1
//   BUSY   out  high from acceptance until the ACK cycle ends
//   SW     in   board switches (already synchronised)
//   LED    out  LED register
module mem_wait_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter int                DEPTH       = 128,
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] LED_ADDR    = 8'hF0,
  parameter logic [ADDR_W-1:0] SW_ADDR     = 8'hF1,
  parameter int                LED_W       = 8,
  parameter string             INIT_FILE   = ""
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                REQ,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] BE,
  output logic [DATA_W-1:0]   RDATA,
  output logic                ACK,
  output logic                ERR,
  output logic                BUSY,
  input  logic [LED_W-1:0]    SW,
  output logic [LED_W-1:0]    LED
);

  localparam int         NB        = DATA_W / 8;
  localparam int         RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LOAD   = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [NB-1:0]     lat_be;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              accept;
  logic              access;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [DATA_W-1:0] acc_wdata;
  logic [NB-1:0]     acc_be;
  logic [RAM_AW-1:0] ram_idx;
  logic              in_ram;
  logic              is_led;
  logic              is_sw;
  logic              ram_we;
  logic              led_we;

  assign accept = REQ && ((state == S_IDLE) || (state == S_RESP));

  // The access happens on the edge that enters RESP. With zero wait states
  // that is the acceptance edge itself, so the live inputs are used; otherwise
  // it is the last WAIT edge and the latched request is used.
  assign access = ((state == S_WAIT) && (cnt == 4'd1)) || (ZERO_WAIT && accept);

  assign acc_addr  = (state == S_WAIT) ? lat_addr  : ADDR;
  assign acc_we    = (state == S_WAIT) ? lat_we    : WE;
  assign acc_wdata = (state == S_WAIT) ? lat_wdata : WDATA;
  assign acc_be    = (state == S_WAIT) ? lat_be    : BE;

  assign ram_idx = acc_addr[RAM_AW-1:0];
  assign in_ram  = ({1'b0, acc_addr} < (ADDR_W+1)'(DEPTH));
  // RAM decode takes priority should an MMIO address overlap the RAM range.
  assign is_led  = !in_ram && (acc_addr == LED_ADDR);
  assign is_sw   = !in_ram && !is_led && (acc_addr == SW_ADDR);
  assign ram_we  = access && acc_we && in_ram;
  assign led_we  = access && acc_we && is_led && acc_be[0];

  // RAM write port, no reset so it maps onto block RAM. A reset during WAIT
  // forces state to IDLE, which removes ram_we before the access edge.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) begin
          mem[ram_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_be    <= '0;
      RDATA     <= '0;
      ACK       <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
      LED       <= '0;
    end else begin
      ACK <= 1'b0;

      if (access) begin
        ACK <= 1'b1;
        ERR <= !(in_ram || is_led || is_sw);
        if (acc_we) begin
          RDATA <= '0;
        end else if (in_ram) begin
          RDATA <= mem[ram_idx];
        end else if (is_led) begin
          RDATA <= DATA_W'(LED);
        end else if (is_sw) begin
          RDATA <= DATA_W'(SW);
        end else begin
          RDATA <= '0;
        end
      end

      if (led_we) begin
        LED <= acc_wdata[LED_W-1:0];
      end

      case (state)
        S_IDLE, S_RESP: begin
          if (REQ) begin
            lat_addr  <= ADDR;
            lat_we    <= WE;
            lat_wdata <= WDATA;
            lat_be    <= BE;
            BUSY      <= 1'b1;
            if (ZERO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WS_LOAD;
            end
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        S_WAIT: begin
          // REQ is ignored here; the counter alone decides when to respond.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb_mem_wait_ctrl: directed testbench for mem_wait_ctrl. Two instances are
// used: u_dut2 with two wait states and u_dut0 with zero wait states.
module tb_mem_wait_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  sw;

  logic        req, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack, err, busy;
  logic [7:0]  led;

  logic        req0, we0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic [3:0]  be0;
  logic [31:0] rdata0;
  logic        ack0, err0, busy0;
  logic [7:0]  led0;

  int checks = 0;
  int passed = 0;

  mem_wait_ctrl #(.WAIT_STATES(2)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .WE(we), .ADDR(addr),
    .WDATA(wdata), .BE(be), .RDATA(rdata), .ACK(ack), .ERR(err),
    .BUSY(busy), .SW(sw), .LED(led)
  );

  mem_wait_ctrl #(.WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req0), .WE(we0), .ADDR(addr0),
    .WDATA(wdata0), .BE(be0), .RDATA(rdata0), .ACK(ack0), .ERR(err0),
    .BUSY(busy0), .SW(sw), .LED(led0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one transaction starting at a negedge, drops REQ after the
  // acceptance edge and returns at the negedge where ACK is seen.
  // lat = number of rising edges from acceptance to ACK visible, -1 on timeout.
  task automatic access(input bit zw, input bit w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int lat, output logic [31:0] rd, output logic e);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    if (zw) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
    end else begin
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
    end
    while (!got && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) begin
        req = 1'b0;
        req0 = 1'b0;
      end
      got = zw ? (ack0 === 1'b1) : (ack === 1'b1);
    end
    lat = got ? n : -1;
    rd = zw ? rdata0 : rdata;
    e = zw ? err0 : err;
    $display("txn ws=%0d we=%0b addr=%02h wdata=%08h be=%h -> lat=%0d rdata=%08h err=%0b",
             zw ? 0 : 2, w, a, d, b, lat, rd, e);
  endtask

  task automatic test_reset();
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passed++;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%08h exp=0", rdata); else passed++;
    checks++; if (led !== 8'h0) $display("FAIL reset_led got=%02h exp=0", led); else passed++;
    checks++; if (ack0 !== 1'b0 || busy0 !== 1'b0 || led0 !== 8'h0)
      $display("FAIL reset_dut0 got ack=%b busy=%b led=%02h exp 0/0/00", ack0, busy0, led0);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; logic [31:0] rd; logic e;
    access(0, 1'b1, 8'h03, 32'hDEADBEEF, 4'hF, lat, rd, e);
    checks++; if (lat != 3) $display("FAIL basic_wr_latency got=%0d exp=3", lat); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL basic_wr_rdata got=%08h exp=0", rd); else passed++;
    checks++; if (e !== 1'b0) $display("FAIL basic_wr_err got=%b exp=0", e); else passed++;
    @(negedge clk);
    checks++; if (ack !== 1'b0) $display("FAIL basic_ack_width got=%b exp=0", ack); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_idle got=%b exp=0", busy); else passed++;
    access(0, 1'b0, 8'h03, 32'h0, 4'h0, lat, rd, e);
    checks++; if (lat != 3) $display("FAIL basic_rd_latency got=%0d exp=3", lat); else passed++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_rd_data got=%08h exp=DEADBEEF", rd); else passed++;
    checks++; if (e !== 1'b0) $display("FAIL basic_rd_err got=%b exp=0", e); else passed++;
    @(negedge clk);
    checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL basic_rdata_hold got=%08h exp=DEADBEEF", rdata); else passed++;
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic e;
    access(0, 1'b1, 8'h03, 32'h11223344, 4'b0101, lat, rd, e);
    access(0, 1'b0, 8'h03, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'hDE22BE44) $display("FAIL lanes_merge got=%08h exp=DE22BE44", rd); else passed++;
    access(0, 1'b1, 8'h03, 32'hFFFFFFFF, 4'b0000, lat, rd, e);
    checks++; if (lat != 3) $display("FAIL lanes_be0_ack got lat=%0d exp=3", lat); else passed++;
    access(0, 1'b0, 8'h03, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'hDE22BE44) $display("FAIL lanes_be0_nochange got=%08h exp=DE22BE44", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    int n; int m; bit busy_ok; bit got;
    logic [31:0] rd1;
    busy_ok = 1'b1;
    req = 1'b1; we = 1'b0; addr = 8'h03; wdata = 32'h0; be = 4'h0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      got = (ack === 1'b1);
    end
    rd1 = rdata;
    // REQ stays high through the ACK cycle: the next read is accepted at once.
    m = 0; got = 1'b0;
    while (!got && m < 20) begin
      @(posedge clk); @(negedge clk); m++;
      if (m == 1) req = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      got = (ack === 1'b1);
    end
    $display("txn b2b first_lat=%0d gap=%0d rdata1=%08h rdata2=%08h", n, m, rd1, rdata);
    checks++; if (n != 3) $display("FAIL b2b_first_latency got=%0d exp=3", n); else passed++;
    checks++; if (m != 3) $display("FAIL b2b_gap got=%0d exp=3", m); else passed++;
    checks++; if (!busy_ok) $display("FAIL b2b_busy got=dropped exp=held"); else passed++;
    checks++; if (rd1 !== 32'hDE22BE44 || rdata !== 32'hDE22BE44)
      $display("FAIL b2b_rdata got=%08h/%08h exp=DE22BE44", rd1, rdata);
    else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ack !== 1'b0)
      $display("FAIL b2b_idle got busy=%b ack=%b exp 0/0", busy, ack);
    else passed++;
  endtask

  task automatic test_mmio();
    int lat; logic [31:0] rd; logic e;
    access(0, 1'b1, 8'hF0, 32'h000000A5, 4'h1, lat, rd, e);
    checks++; if (led !== 8'hA5) $display("FAIL mmio_led got=%02h exp=A5", led); else passed++;
    checks++; if (e !== 1'b0) $display("FAIL mmio_led_err got=%b exp=0", e); else passed++;
    sw = 8'h3C;
    access(0, 1'b0, 8'hF1, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h0000003C) $display("FAIL mmio_sw_rd got=%08h exp=0000003C", rd); else passed++;
    access(0, 1'b0, 8'hF0, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h000000A5) $display("FAIL mmio_led_rd got=%08h exp=000000A5", rd); else passed++;
    access(0, 1'b1, 8'hF0, 32'h000000FF, 4'hE, lat, rd, e);
    checks++; if (led !== 8'hA5) $display("FAIL mmio_led_be0 got=%02h exp=A5", led); else passed++;
    access(0, 1'b1, 8'hF1, 32'h000000FF, 4'hF, lat, rd, e);
    checks++; if (e !== 1'b0 || led !== 8'hA5)
      $display("FAIL mmio_sw_wr got err=%b led=%02h exp 0/A5", e, led);
    else passed++;
  endtask

  task automatic test_boundary();
    int lat; logic [31:0] rd; logic e;
    access(0, 1'b1, 8'h7F, 32'h7F7F7F7F, 4'hF, lat, rd, e);
    access(0, 1'b1, 8'h00, 32'hA0A0A0A0, 4'hF, lat, rd, e);
    access(0, 1'b1, 8'h80, 32'hFFFFFFFF, 4'hF, lat, rd, e);
    checks++; if (e !== 1'b1) $display("FAIL bound_80_wr_err got=%b exp=1", e); else passed++;
    access(0, 1'b0, 8'h7F, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h7F7F7F7F || e !== 1'b0)
      $display("FAIL bound_7f_rd got=%08h err=%b exp=7F7F7F7F err=0", rd, e);
    else passed++;
    access(0, 1'b0, 8'h00, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'hA0A0A0A0) $display("FAIL bound_alias got=%08h exp=A0A0A0A0", rd); else passed++;
    access(0, 1'b0, 8'h80, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h0 || e !== 1'b1)
      $display("FAIL bound_80_rd got=%08h err=%b exp=00000000 err=1", rd, e);
    else passed++;
  endtask

  task automatic test_error_zero_wait();
    int lat; logic [31:0] rd; logic e;
    access(1, 1'b1, 8'h03, 32'hCAFEF00D, 4'hF, lat, rd, e);
    checks++; if (lat != 1) $display("FAIL zw_wr_latency got=%0d exp=1", lat); else passed++;
    access(1, 1'b1, 8'h10, 32'h01020304, 4'hF, lat, rd, e);
    access(1, 1'b1, 8'hF0, 32'h0000005A, 4'hF, lat, rd, e);
    access(1, 1'b1, 8'h90, 32'hFFFFFFFF, 4'hF, lat, rd, e);
    checks++; if (lat != 1) $display("FAIL zw_err_latency got=%0d exp=1", lat); else passed++;
    checks++; if (e !== 1'b1) $display("FAIL zw_err_wr got=%b exp=1", e); else passed++;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) $display("FAIL zw_ack_width got=%b exp=0", ack0); else passed++;
    checks++; if (led0 !== 8'h5A) $display("FAIL zw_led_unchanged got=%02h exp=5A", led0); else passed++;
    access(1, 1'b0, 8'h90, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h0 || e !== 1'b1)
      $display("FAIL zw_err_rd got=%08h err=%b exp=00000000 err=1", rd, e);
    else passed++;
    access(1, 1'b0, 8'h10, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h01020304 || e !== 1'b0)
      $display("FAIL zw_ram_unchanged got=%08h err=%b exp=01020304 err=0", rd, e);
    else passed++;
    access(1, 1'b0, 8'h03, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'hCAFEF00D) $display("FAIL zw_rd got=%08h exp=CAFEF00D", rd); else passed++;
  endtask

  task automatic test_reset_mid_txn();
    int lat; logic [31:0] rd; logic e; bit bad;
    access(0, 1'b1, 8'hF0, 32'h00000077, 4'h1, lat, rd, e);
    access(0, 1'b1, 8'h05, 32'h55AA55AA, 4'hF, lat, rd, e);
    checks++; if (led !== 8'h77) $display("FAIL rst_led_pre got=%02h exp=77", led); else passed++;
    req = 1'b1; we = 1'b1; addr = 8'h05; wdata = 32'h12345678; be = 4'hF;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL rst_accepted got busy=%b exp=1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || led !== 8'h00 || ack !== 1'b0)
      $display("FAIL rst_async got busy=%b led=%02h ack=%b exp 0/00/0", busy, led, ack);
    else passed++;
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack !== 1'b0) bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ack !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL rst_no_ack got=ack_or_busy_seen exp=quiet"); else passed++;
    access(0, 1'b0, 8'h05, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h55AA55AA) $display("FAIL rst_no_write got=%08h exp=55AA55AA", rd); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; sw = 8'h00;
    req = 1'b0; we = 1'b0; addr = 8'h0; wdata = 32'h0; be = 4'h0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h0; wdata0 = 32'h0; be0 = 4'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
    test_mmio();
    test_boundary();
    test_error_zero_wait();
    test_reset_mid_txn();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
